// File: rtl/ste_pkg.sv
// Shared types and bus polarity constants for the STEbus I/O-window initiator.
package ste_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RELEASE,
      ST_DONE
   } state_t;

   localparam logic CM0_WR   = 1'b0;
   localparam logic CM0_RD   = 1'b1;
   localparam logic CE_ON    = 1'b0;
   localparam logic CE_OFF   = 1'b1;
   localparam logic DACK_ON  = 1'b0;
   localparam logic DACK_OFF = 1'b1;
   localparam logic ACK_ON   = 1'b1;

endpackage

// File: rtl/ste_sync.sv
// Generic two-flop synchronizer; resets to RST_VAL so an active-low strobe reads as idle.
module ste_sync #(
   parameter int         W       = 1,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ste_master.sv
// STEbus initiator: sequences one read/write per request with strobe, DATACK handshake and timeouts.
import ste_pkg::*;

module ste_master #(
   parameter int ADDR_W    = 5,
   parameter int SETUP_CYC = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              ack,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data_out,
   output logic              bus_data_oe,
   input  logic [DATA_W-1:0] bus_data_in,
   output logic              bus_cm0,
   output logic              bus_ce,
   input  logic              bus_datack
);

   localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

   function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                flag, flag_nxt;
   logic                ce_nxt, cm0_nxt, oe_nxt, ack_nxt, err_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   dout_nxt, rdata_nxt;
   logic                datack_s;
   logic                dack;

   ste_sync #(.W(1), .RST_VAL(DACK_OFF)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus_datack),
      .q     (datack_s)
   );

   assign dack = (datack_s == DACK_ON);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      flag_nxt  = flag;
      ce_nxt    = bus_ce;
      cm0_nxt   = bus_cm0;
      oe_nxt    = bus_data_oe;
      addr_nxt  = bus_addr;
      dout_nxt  = bus_data_out;
      rdata_nxt = rdata;
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      busy      = (state != ST_IDLE);
      unique case (state)
         ST_IDLE: begin
            busy = req;
            if (req) begin
               addr_nxt  = addr;
               dout_nxt  = wdata;
               cm0_nxt   = we ? CM0_WR : CM0_RD;
               oe_nxt    = we;
               cnt_nxt   = SETUP_LD;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               ce_nxt    = CE_ON;
               cnt_nxt   = TIMEOUT_LD;
               state_nxt = ST_STROBE;
            end else begin
               cnt_nxt = sat_dec(cnt);
            end
         end
         ST_STROBE: begin
            // Either outcome releases the strobe; a missing DATACK only marks the error.
            if (dack || cnt == '0) begin
               if (dack && bus_cm0 == CM0_RD) rdata_nxt = bus_data_in;
               if (!dack) flag_nxt = 1'b1;
               ce_nxt    = CE_OFF;
               cnt_nxt   = TIMEOUT_LD;
               state_nxt = ST_RELEASE;
            end else begin
               cnt_nxt = sat_dec(cnt);
            end
         end
         ST_RELEASE: begin
            if (!dack || cnt == '0) begin
               ack_nxt   = ACK_ON;
               err_nxt   = flag | dack;
               oe_nxt    = 1'b0;
               cm0_nxt   = CM0_RD;
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = sat_dec(cnt);
            end
         end
         ST_DONE: begin
            flag_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         flag         <= 1'b0;
         bus_ce       <= CE_OFF;
         bus_cm0      <= CM0_RD;
         bus_data_oe  <= 1'b0;
         bus_addr     <= '0;
         bus_data_out <= '0;
         rdata        <= '0;
         ack          <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         flag         <= flag_nxt;
         bus_ce       <= ce_nxt;
         bus_cm0      <= cm0_nxt;
         bus_data_oe  <= oe_nxt;
         bus_addr     <= addr_nxt;
         bus_data_out <= dout_nxt;
         rdata        <= rdata_nxt;
         ack          <= ack_nxt;
         err          <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ste_master.sv
// Bench for ste_master: behavioural slave plus transfer-level timing/result model.
module tb_ste_master;

   localparam int ADDR_W    = 5;
   localparam int SETUP_CYC = 2;
   localparam int TIMEOUT   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic              busy;
   logic              ack;
   logic              err;
   logic [7:0]        rdata;
   logic [ADDR_W-1:0] bus_addr;
   logic [7:0]        bus_data_out;
   logic              bus_data_oe;
   logic [7:0]        bus_data_in;
   logic              bus_cm0;
   logic              bus_ce;
   logic              bus_datack;

   int         tests = 0;
   int         fails = 0;
   bit         sl_never = 1'b1;
   int         sl_d = 0;
   int         sl_r = 0;
   logic [7:0] sl_data = 8'h00;
   logic [7:0] exp_rdata = 8'h00;

   always #5 clk = ~clk;

   ste_master #(.ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .busy         (busy),
      .ack          (ack),
      .err          (err),
      .rdata        (rdata),
      .bus_addr     (bus_addr),
      .bus_data_out (bus_data_out),
      .bus_data_oe  (bus_data_oe),
      .bus_data_in  (bus_data_in),
      .bus_cm0      (bus_cm0),
      .bus_ce       (bus_ce),
      .bus_datack   (bus_datack)
   );

   // Slave: asserts DATACK sl_d cycles after seeing the strobe, releases sl_r cycles after strobe release.
   initial begin
      int guard;
      bus_datack  = 1'b1;
      bus_data_in = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (bus_ce === 1'b0 && !sl_never) begin
            repeat (sl_d) begin @(posedge clk); #1; end
            bus_datack  = 1'b0;
            bus_data_in = sl_data;
            guard = 0;
            while (bus_ce === 1'b0 && guard < 200) begin @(posedge clk); #1; guard++; end
            repeat (sl_r) begin @(posedge clk); #1; end
            bus_datack = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_xfer(input bit w, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                           input bit never, input int dl, input int rl, input logic [7:0] sd,
                           input bit poke, input bit b2b);
      int  guard, lat, ce_low, exp_s, exp_r, exp_lat;
      bit  saw_oe, exp_err;
      guard = 0;
      while (bus_datack === 1'b0 && guard < 100) begin @(posedge clk); #1; guard++; end
      if (!b2b) repeat (2) begin @(posedge clk); #1; end
      sl_never = never; sl_d = dl; sl_r = rl; sl_data = sd;
      exp_s   = never ? TIMEOUT : dl + 3;
      exp_r   = never ? 1 : ((rl + 3 > TIMEOUT) ? TIMEOUT : rl + 3);
      exp_err = never || (rl + 3 > TIMEOUT);
      exp_lat = SETUP_CYC + exp_s + exp_r;
      if (!w && !never) exp_rdata = sd;

      we = w; addr = a; wdata = d; req = 1'b1;
      #1 chk("busy_accept", busy, 1);
      @(posedge clk); #1;
      req = 1'b0;
      chk("bus_addr", bus_addr, a);
      chk("bus_cm0", bus_cm0, w ? 0 : 1);
      chk("bus_oe", bus_data_oe, w);
      if (w) chk("bus_dout", bus_data_out, d);

      lat = 0; ce_low = 0; saw_oe = bus_data_oe;
      while (ack !== 1'b1 && lat < 400) begin
         if (poke && lat == 3) begin req = 1'b1; addr = ~a; we = ~w; end
         else if (poke && lat == 4) req = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (bus_ce === 1'b0) ce_low++;
         if (bus_data_oe === 1'b1) saw_oe = 1'b1;
      end
      req = 1'b0; addr = a; we = w;
      chk("latency", lat, exp_lat);
      chk("ce_low", ce_low, exp_s);
      chk("err", err, exp_err);
      chk("rdata", rdata, exp_rdata);
      chk("addr_hold", bus_addr, a);
      chk("oe_done", bus_data_oe, 0);
      chk("cm0_done", bus_cm0, 1);
      chk("busy_ack", busy, 1);
      if (!w) chk("oe_read", saw_oe, 0);
      @(posedge clk); #1;
      chk("ack_pulse", ack, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int guard, acks;
      reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ce", bus_ce, 1);
      chk("rst_cm0", bus_cm0, 1);
      chk("rst_oe", bus_data_oe, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_dout", bus_data_out, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;

      run_xfer(1'b1, 5'h02, 8'hA5, 1'b0, 4, 0, 8'h00, 1'b0, 1'b0);
      run_xfer(1'b0, 5'h08, 8'h00, 1'b0, 1, 2, 8'h3C, 1'b0, 1'b0);
      run_xfer(1'b0, 5'h11, 8'h00, 1'b1, 0, 0, 8'hEE, 1'b0, 1'b0);
      run_xfer(1'b1, 5'h07, 8'h33, 1'b0, 0, 30, 8'h00, 1'b0, 1'b0);
      run_xfer(1'b0, 5'h15, 8'h00, 1'b0, TIMEOUT - 3, TIMEOUT - 3, 8'h5A, 1'b0, 1'b0);
      run_xfer(1'b1, 5'h04, 8'h11, 1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
      run_xfer(1'b1, 5'h1F, 8'hC3, 1'b0, 0, 0, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of a strobe.
      repeat (2) @(posedge clk);
      #1;
      sl_never = 1'b1;
      we = 1'b0; addr = 5'h03; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      guard = 0;
      while (bus_ce !== 1'b0 && guard < 20) begin @(posedge clk); #1; guard++; end
      chk("rst_mid_ce_low", bus_ce, 0);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_ce", bus_ce, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_ack", ack, 0);
      chk("rstmid_cm0", bus_cm0, 1);
      chk("rstmid_oe", bus_data_oe, 0);
      chk("rstmid_rdata", rdata, 0);
      exp_rdata = 8'h00;
      reset = 1'b1;
      acks = 0;
      repeat (TIMEOUT + 4) begin @(posedge clk); #1; if (ack === 1'b1) acks++; end
      chk("rstmid_no_ack", acks, 0);

      for (int i = 0; i < 20; i++) begin
         bit         w, nv;
         int         dl, rl;
         logic [4:0] a;
         logic [7:0] d, sd;
         w  = 1'($urandom_range(0, 1));
         a  = 5'($urandom);
         d  = 8'($urandom);
         sd = 8'($urandom);
         nv = ($urandom_range(0, 5) == 0);
         dl = $urandom_range(0, TIMEOUT - 3);
         rl = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 8)
                                          : $urandom_range(0, TIMEOUT - 3);
         run_xfer(w, a, d, nv, dl, rl, sd, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
